carry_lookahead_adder_4bit: RTL and testbench

//   4-bit carry-lookahead adder: Sum/Cout = A + B + Cin, all carries computed in

---
 rtl/carry_lookahead_adder_4bit.sv | 53 +++++
 tb/tb_carry_lookahead_adder_4bit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/carry_lookahead_adder_4bit.sv
// rtl/carry_lookahead_adder_4bit.sv - 4-bit carry-lookahead adder with group P/G and registered result
module carry_lookahead_adder_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       P_grp,
  output logic       G_grp,
  output logic [3:0] Sum_q,
  output logic       Cout_q
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] sum_d;
  logic       cout_d;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat sum-of-products of g/p/Cin so no carry waits on another.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum   = p ^ c[3:0];
  assign Cout  = c[4];
  assign P_grp = &p;
  assign G_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

  assign sum_d  = Sum;
  assign cout_d = Cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum_q  <= 4'b0000;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= sum_d;
      Cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder_4bit.sv
// tb/tb_carry_lookahead_adder_4bit.sv - randomized self-checking bench for carry_lookahead_adder_4bit
module tb_carry_lookahead_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       P_grp;
  logic       G_grp;
  logic [3:0] Sum_q;
  logic       Cout_q;

  int n_checks;
  int n_errors;

  carry_lookahead_adder_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .P_grp  (P_grp),
    .G_grp  (G_grp),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (A=%0h B=%0h Cin=%0b)", tag, obs, exp, A, B, Cin);
    end
  endtask

  // Reference: plain integer addition; G_grp is the carry with Cin=0, P_grp is all bits differing.
  task automatic check_comb(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int total;
    int total_nc;
    total    = int'(a) + int'(b) + int'(cin);
    total_nc = int'(a) + int'(b);
    check("sum",   {4'b0, Sum},   8'(total % 16));
    check("cout",  {7'b0, Cout},  8'(total / 16));
    check("p_grp", {7'b0, P_grp}, ((a ^ b) == 4'hF) ? 8'd1 : 8'd0);
    check("g_grp", {7'b0, G_grp}, (total_nc > 15) ? 8'd1 : 8'd0);
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int total;
    total = int'(a) + int'(b) + int'(cin);
    check("sum_q",  {4'b0, Sum_q},  8'(total % 16));
    check("cout_q", {7'b0, Cout_q}, 8'(total / 16));
  endtask

  // Drives one vector just after a rising edge, checks it combinationally, then after the next edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
    A = a; B = b; Cin = cin;
    #1;
    check_comb(a, b, cin);
    @(posedge clk);
    #1;
    check_reg(a, b, cin);
  endtask

  logic [8:0] order [512];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    A = 4'h0; B = 4'h0; Cin = 1'b0;
    #1;
    check("rst_sum_q",  {4'b0, Sum_q},  8'h00);
    check("rst_cout_q", {7'b0, Cout_q}, 8'h00);
    check_comb(4'h0, 4'h0, 1'b0);
    A = 4'hF; B = 4'h1; Cin = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_sum_q",  {4'b0, Sum_q},  8'h00);
    check("rst_hold_cout_q", {7'b0, Cout_q}, 8'h00);
    check_comb(4'hF, 4'h1, 1'b1);
    rst = 1'b0;

    apply(4'h0, 4'h0, 1'b0);
    apply(4'h1, 4'h1, 1'b0);
    apply(4'h3, 4'h2, 1'b1);
    apply(4'h5, 4'h5, 1'b0);
    apply(4'hA, 4'h5, 1'b0);
    apply(4'hF, 4'h1, 1'b1);

    // Asynchronous clear mid-cycle; combinational outputs keep following the inputs.
    #2;
    rst = 1'b1;
    #1;
    check("async_sum_q",  {4'b0, Sum_q},  8'h00);
    check("async_cout_q", {7'b0, Cout_q}, 8'h00);
    check_comb(4'hF, 4'h1, 1'b1);
    @(posedge clk);
    #1;
    check("held_sum_q", {4'b0, Sum_q}, 8'h00);
    rst = 1'b0;
    apply(4'hF, 4'hF, 1'b1);

    // Every {A,B,Cin} combination once, in a random order.
    for (int i = 0; i < 512; i++) order[i] = 9'(i);
    for (int i = 511; i > 0; i--) begin
      int j;
      logic [8:0] t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      apply(order[i][8:5], order[i][4:1], order[i][0]);
    end

    for (int i = 0; i < 64; i++) begin
      apply(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
